// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter sequencing controller.
// Optional feature macro used by the controller: OVF_ABORT_EN.
package counter_ctrl_pkg;

    // Controller phases: arbitrate, announce grant, issue steps, report.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_LEN_W   = 8;
    localparam int MIN_NUM_REQ = 2;
    localparam int MAX_NUM_REQ = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting index at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // Scan from ptr upward (mod NUM_REQ), keep the first hit.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Round-robin scheduler sharing one up/down counter among NUM_REQ clients.
// Each grant drives cnt_enable/cnt_up_down for the latched number of steps,
// then pulses done with id and overflow status.
// Optional feature macro: OVF_ABORT_EN (abort a run on counter overflow).
//
// Handshake: req[i] is a level request that the client holds until it sees
// done with done_id == i; done/done_id/done_ovf/done_abort form a one-cycle
// valid pulse with no back-pressure. gnt is held from GRANT through DONE.
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_dir,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    input  logic                       pause,
    input  logic                       cnt_overflow,
    output logic                       cnt_enable,
    output logic                       cnt_up_down,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic                       done_ovf,
    output logic                       done_abort,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;

    logic [IDX_W-1:0]     id_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 dir_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     rem_q;
    logic                 ovf_q;
    logic                 en_seen_q;
    logic                 ovf_cond;
    logic                 abort_fire;
`ifdef OVF_ABORT_EN
    logic                 abort_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winner, count down steps, accumulate overflow, advance pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q      <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            dir_q     <= 1'b0;
            len_q     <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            en_seen_q <= 1'b0;
`ifdef OVF_ABORT_EN
            abort_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        id_q  <= arb_idx;
                        gnt_q <= arb_gnt;
                        dir_q <= req_dir[arb_idx];
                        len_q <= req_len[arb_idx*LEN_W +: LEN_W];
                    end
                end
                ST_GRANT: begin
                    rem_q     <= len_q;
                    ovf_q     <= 1'b0;
                    en_seen_q <= 1'b0;
`ifdef OVF_ABORT_EN
                    abort_q   <= 1'b0;
`endif
                end
                ST_RUN: begin
                    if (cnt_enable) begin
                        rem_q     <= rem_q - LEN_W'(1);
                        en_seen_q <= 1'b1;
                    end
                    ovf_q <= ovf_q | ovf_cond;
`ifdef OVF_ABORT_EN
                    abort_q <= abort_fire;
`endif
                end
                ST_DONE: begin
                    rem_q <= '0;
                    ptr_q <= (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + IDX_W'(1);
                end
                default: begin
                    rem_q <= '0;
                end
            endcase
        end
    end

    // Next state and all outputs; the overflow flag only counts once this
    // grant has issued an enable, so a flag left over from a previous run
    // is ignored.
    always_comb begin
        state_d     = state_q;
        ovf_cond    = cnt_overflow && en_seen_q &&
                      ((state_q == ST_RUN) || (state_q == ST_DONE));
`ifdef OVF_ABORT_EN
        abort_fire  = (state_q == ST_RUN) && ovf_cond;
`else
        abort_fire  = 1'b0;
`endif
        cnt_enable  = (state_q == ST_RUN) && !pause && !abort_fire;
        busy        = (state_q != ST_IDLE);
        cnt_up_down = busy && dir_q;
        gnt         = busy ? gnt_q : '0;
        done        = (state_q == ST_DONE);
        done_id     = done ? id_q : '0;
        done_ovf    = done && (ovf_q || ovf_cond);
`ifdef OVF_ABORT_EN
        done_abort  = done && abort_q;
`else
        done_abort  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_d = (len_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (abort_fire || (cnt_enable && (rem_q == LEN_W'(1)))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Testbench for counter_seq_ctrl with a behavioural counter and run model.
module tb_counter_seq_ctrl;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 8;
`ifdef OVF_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] id;
        logic       ovf;
        logic       abort;
        logic [7:0] n_en;
        logic [7:0] lat;
        logic       dir;
        logic       dir_bad;
    } rec_t;
    localparam int REC_W = $bits(rec_t);

    logic                       clk;
    logic                       rst_n;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         req_dir;
    logic [NUM_REQ*LEN_W-1:0]   req_len;
    logic                       pause;
    logic                       cnt_overflow;
    logic                       cnt_enable;
    logic                       cnt_up_down;
    logic [NUM_REQ-1:0]         gnt;
    logic                       done;
    logic [1:0]                 done_id;
    logic                       done_ovf;
    logic                       done_abort;
    logic                       busy;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;
    int mdl_ptr  = 0;
    bit rnd_pause = 1'b0;

    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] act_q[$];

    counter_seq_ctrl #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_dir      (req_dir),
        .req_len      (req_len),
        .pause        (pause),
        .cnt_overflow (cnt_overflow),
        .cnt_enable   (cnt_enable),
        .cnt_up_down  (cnt_up_down),
        .gnt          (gnt),
        .done         (done),
        .done_id      (done_id),
        .done_ovf     (done_ovf),
        .done_abort   (done_abort),
        .busy         (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- external 8-bit counter ----------------
    logic [7:0] cnt_val = 8'h00;
    logic       cnt_ovf = 1'b0;
    assign cnt_overflow = cnt_ovf;

    always @(posedge clk) begin
        if (cnt_enable) begin
            cnt_ovf <= cnt_up_down ? (cnt_val == 8'hFF) : (cnt_val == 8'h00);
            cnt_val <= cnt_up_down ? cnt_val + 8'd1 : cnt_val - 8'd1;
        end
    end

    // Random pause source used by the randomized scenario.
    always @(posedge clk) begin
        #1;
        if (rnd_pause) pause = ($urandom_range(0, 3) == 0);
    end

    // ---------------- monitor: one record per grant window ----------------
    logic in_win = 1'b0;
    rec_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_win = 1'b0;
        end else begin
            if (cnt_enable && (gnt == '0 || pause)) viol++;
            if (!$onehot0(gnt)) viol++;
            if (done && gnt == '0) viol++;
            if (gnt != '0) begin
                if (!in_win) begin
                    in_win  = 1'b1;
                    cur     = '0;
                    cur.dir = cnt_up_down;
                end
                cur.lat = cur.lat + 8'd1;
                if (cnt_up_down !== cur.dir) cur.dir_bad = 1'b1;
                if (cnt_enable) cur.n_en = cur.n_en + 8'd1;
                if (done) begin
                    cur.id    = done_id;
                    cur.ovf   = done_ovf;
                    cur.abort = done_abort;
                    act_q.push_back(cur);
                    in_win = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int rr_pick(logic [3:0] mask, int ptr);
        for (int i = 0; i < 4; i++) begin
            if (mask[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return 0;
    endfunction

    // Step an 8-bit counter len times from start; a wrap is overflow.
    function automatic rec_t model_run(int id, logic dir, logic [7:0] len, logic [7:0] start);
        rec_t r;
        logic [7:0] v;
        bit wrap;
        r = '0;
        r.id  = 2'(id);
        r.dir = dir;
        v = start;
        for (int s = 1; s <= int'(len); s++) begin
            wrap = dir ? (v == 8'hFF) : (v == 8'h00);
            v = dir ? v + 8'd1 : v - 8'd1;
            r.n_en = r.n_en + 8'd1;
            if (wrap) begin
                r.ovf = 1'b1;
                if (ABORT_EN && s < int'(len)) begin
                    r.abort = 1'b1;
                    break;
                end
            end
        end
        r.lat = r.abort ? r.n_en + 8'd3 : len + 8'd2;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic dir, logic [7:0] len);
        req_dir[i] = dir;
        req_len[i*LEN_W +: LEN_W] = len;
    endtask

    task automatic wait_done(int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (act_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        pause = 1'b0;
        step();
        step();
        rst_n   = 1'b1;
        mdl_ptr = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'hF;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'd3);
        step();
        step();
        checks++; if (cnt_enable !== 1'b0) begin failures++; $display("FAIL reset_enable act=%b exp=0", cnt_enable); end
        checks++; if (cnt_up_down !== 1'b0) begin failures++; $display("FAIL reset_up_down act=%b exp=0", cnt_up_down); end
        checks++; if (gnt !== 4'h0) begin failures++; $display("FAIL reset_gnt act=%h exp=0", gnt); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done act=%b exp=0", done); end
        checks++; if (done_id !== 2'd0) begin failures++; $display("FAIL reset_done_id act=%0d exp=0", done_id); end
        checks++; if (done_ovf !== 1'b0) begin failures++; $display("FAIL reset_done_ovf act=%b exp=0", done_ovf); end
        checks++; if (done_abort !== 1'b0) begin failures++; $display("FAIL reset_done_abort act=%b exp=0", done_abort); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy act=%b exp=0", busy); end
        req = '0;
        rst_n = 1'b1;
        mdl_ptr = 0;
        step();
    endtask

    task automatic test_single();
        rec_t e, a;
        bit ok;
        cnt_val = 8'h10;
        set_req(0, 1'b1, 8'd5);
        exp_q.push_back(model_run(0, 1'b1, 8'd5, cnt_val));
        req = 4'b0001;
        step();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt act=%h exp=1", gnt); end
        checks++; if (cnt_enable !== 1'b0) begin failures++; $display("FAIL single_grant_enable act=%b exp=0", cnt_enable); end
        step();
        checks++; if (cnt_enable !== 1'b1 || cnt_up_down !== 1'b1) begin
            failures++; $display("FAIL single_first_enable act=%b%b exp=11", cnt_enable, cnt_up_down);
        end
        wait_done(50, ok);
        req = '0;
        checks++;
        if (!ok) begin failures++; $display("FAIL single_done_seen act=0 exp=1"); end
        else begin
            a = rec_t'(act_q.pop_front());
            e = rec_t'(exp_q.pop_front());
            if (a !== e) begin failures++; $display("FAIL single_rec act=%h exp=%h", a, e); end
            mdl_ptr = (int'(e.id) + 1) % 4;
        end
    endtask

    task automatic test_round_robin();
        rec_t e, a;
        bit ok;
        int id;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'($urandom_range(0, 1)), 8'd1);
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            id = rr_pick(4'hF, mdl_ptr);
            exp_q.push_back(model_run(id, req_dir[id], 8'd1, cnt_val));
            wait_done(20, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL rr_done_seen k=%0d act=0 exp=1", k); end
            else begin
                a = rec_t'(act_q.pop_front());
                e = rec_t'(exp_q.pop_front());
                if (a !== e) begin failures++; $display("FAIL rr_rec k=%0d act=%h exp=%h", k, a, e); end
                mdl_ptr = (int'(e.id) + 1) % 4;
            end
        end
        req = '0;
        exp_q.delete();
    endtask

    task automatic test_zero_len();
        rec_t e, a;
        bit ok;
        cnt_ovf = 1'b1;
        set_req(2, 1'b1, 8'd0);
        exp_q.push_back(model_run(2, 1'b1, 8'd0, cnt_val));
        req = 4'b0100;
        wait_done(20, ok);
        req = '0;
        checks++;
        if (!ok) begin failures++; $display("FAIL zero_len_done_seen act=0 exp=1"); end
        else begin
            a = rec_t'(act_q.pop_front());
            e = rec_t'(exp_q.pop_front());
            if (a !== e) begin failures++; $display("FAIL zero_len_rec act=%h exp=%h", a, e); end
            mdl_ptr = (int'(e.id) + 1) % 4;
        end
    endtask

    task automatic test_pause();
        rec_t e, a;
        bit ok;
        cnt_val = 8'h80;
        set_req(1, 1'b0, 8'd4);
        e = model_run(1, 1'b0, 8'd4, cnt_val);
        e.lat = e.lat + 8'd3;
        exp_q.push_back(e);
        req = 4'b0010;
        step(); step(); step();
        pause = 1'b1;
        step(); step(); step();
        pause = 1'b0;
        wait_done(50, ok);
        req = '0;
        checks++;
        if (!ok) begin failures++; $display("FAIL pause_done_seen act=0 exp=1"); end
        else begin
            a = rec_t'(act_q.pop_front());
            e = rec_t'(exp_q.pop_front());
            if (a !== e) begin failures++; $display("FAIL pause_rec act=%h exp=%h", a, e); end
            mdl_ptr = (int'(e.id) + 1) % 4;
        end
    endtask

    task automatic test_overflow();
        rec_t e, a;
        bit ok;
        int         ids[3]    = '{0, 3, 1};
        logic       dirs[3]   = '{1'b1, 1'b0, 1'b1};
        logic [7:0] lens[3]   = '{8'd4, 8'd3, 8'd2};
        logic [7:0] starts[3] = '{8'hFE, 8'h01, 8'hFE};
        for (int k = 0; k < 3; k++) begin
            cnt_val = starts[k];
            set_req(ids[k], dirs[k], lens[k]);
            exp_q.push_back(model_run(ids[k], dirs[k], lens[k], cnt_val));
            req = '0;
            req[ids[k]] = 1'b1;
            wait_done(50, ok);
            req = '0;
            checks++;
            if (!ok) begin failures++; $display("FAIL ovf_done_seen k=%0d act=0 exp=1", k); end
            else begin
                a = rec_t'(act_q.pop_front());
                e = rec_t'(exp_q.pop_front());
                if (a !== e) begin failures++; $display("FAIL ovf_rec k=%0d act=%h exp=%h", k, a, e); end
                mdl_ptr = (int'(e.id) + 1) % 4;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        rec_t e, a;
        bit ok;
        int id;
        cnt_val = 8'h40;
        set_req(0, 1'b1, 8'd2);
        set_req(2, 1'b0, 8'd2);
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            id = rr_pick(4'b0101, mdl_ptr);
            exp_q.push_back(model_run(id, req_dir[id], 8'd2, cnt_val));
            wait_done(30, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL b2b_done_seen k=%0d act=0 exp=1", k); end
            else begin
                a = rec_t'(act_q.pop_front());
                e = rec_t'(exp_q.pop_front());
                if (a !== e) begin failures++; $display("FAIL b2b_rec k=%0d act=%h exp=%h", k, a, e); end
                mdl_ptr = (int'(e.id) + 1) % 4;
            end
        end
        req = '0;
        exp_q.delete();
    endtask

    task automatic test_random();
        rec_t e, a;
        bit ok;
        int id;
        logic [3:0] mask;
        logic [7:0] picks[5];
        rnd_pause = 1'b1;
        for (int k = 0; k < 16; k++) begin
            picks = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'($urandom_range(0, 255))};
            cnt_val = picks[$urandom_range(0, 4)];
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 6)));
            id = rr_pick(mask, mdl_ptr);
            exp_q.push_back(model_run(id, req_dir[id], req_len[id*LEN_W +: LEN_W], cnt_val));
            req = mask;
            step();
            for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 6)));
            if ($urandom_range(0, 1) == 1) req = '0;
            wait_done(200, ok);
            req = '0;
            checks++;
            if (!ok) begin failures++; $display("FAIL rand_done_seen k=%0d act=0 exp=1", k); end
            else begin
                a = rec_t'(act_q.pop_front());
                e = rec_t'(exp_q.pop_front());
                if ({a.id, a.ovf, a.abort, a.n_en, a.dir, a.dir_bad} !==
                    {e.id, e.ovf, e.abort, e.n_en, e.dir, e.dir_bad}) begin
                    failures++; $display("FAIL rand_rec k=%0d act=%h exp=%h", k, a, e);
                end
                mdl_ptr = (int'(e.id) + 1) % 4;
            end
        end
        rnd_pause = 1'b0;
        step();
        pause = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset_mid_run();
        rec_t e, a;
        bit ok;
        cnt_val = 8'h20;
        set_req(1, 1'b1, 8'd10);
        req = 4'b0010;
        step(); step(); step(); step();
        checks++; if (cnt_enable !== 1'b1) begin failures++; $display("FAIL midrst_pre_enable act=%b exp=1", cnt_enable); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (cnt_enable !== 1'b0) begin failures++; $display("FAIL midrst_enable act=%b exp=0", cnt_enable); end
        checks++; if (busy !== 1'b0 || gnt !== 4'h0) begin
            failures++; $display("FAIL midrst_idle act=busy%b_gnt%h exp=busy0_gnt0", busy, gnt);
        end
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'd1);
        req = 4'hF;
        step(); step();
        rst_n = 1'b1;
        mdl_ptr = 0;
        exp_q.push_back(model_run(rr_pick(4'hF, mdl_ptr), 1'b1, 8'd1, cnt_val));
        wait_done(20, ok);
        req = '0;
        checks++;
        if (!ok) begin failures++; $display("FAIL midrst_done_seen act=0 exp=1"); end
        else begin
            a = rec_t'(act_q.pop_front());
            e = rec_t'(exp_q.pop_front());
            if (a !== e) begin failures++; $display("FAIL midrst_rec act=%h exp=%h", a, e); end
            mdl_ptr = (int'(e.id) + 1) % 4;
        end
        step(); step(); step(); step();
        checks++; if (act_q.size() != 0) begin failures++; $display("FAIL midrst_stray_done act=%0d exp=0", act_q.size()); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst_n   = 1'b0;
        req     = '0;
        req_dir = '0;
        req_len = '0;
        pause   = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_pause();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        checks++; if (viol != 0) begin failures++; $display("FAIL protocol_violations act=%0d exp=0", viol); end
        checks++; if (act_q.size() != 0) begin failures++; $display("FAIL leftover_records act=%0d exp=0", act_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
